// File: rtl/accel_host_sequencer.sv
// Host-side sequencer for the accelerator register bus: writes A, B, opcode, waits, reads the 16-bit result.
// Optional ACCEL_READBACK_EN adds readback checks of A and B after they are written, reported on rsp_err.
module accel_host_sequencer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic [3:0]  bus_address,
    output logic        bus_data_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_B, S_RB_A, S_RB_B, S_WR_OP,
        S_WAIT, S_RD_LO, S_RD_HI, S_RESP
    } state_t;

    localparam bit         SKIP_WAIT   = (WAIT_CYCLES == 0);
    localparam int         WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_LOAD_I);

    state_t      state, state_nxt;
    logic [7:0]  a_q, b_q;
    logic [2:0]  op_q;
    logic [3:0]  wait_cnt;
    logic        accept;

    assign accept = (state == S_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Bus outputs depend only on the registered state and the latched job.
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        busy           = 1'b1;
        bus_address    = 4'hF;
        bus_data_write = 1'b0;
        bus_data_out   = 8'h00;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = S_WR_A;
            end
            S_WR_A: begin
                bus_address    = 4'h0;
                bus_data_write = 1'b1;
                bus_data_out   = a_q;
                state_nxt      = S_WR_B;
            end
            S_WR_B: begin
                bus_address    = 4'h1;
                bus_data_write = 1'b1;
                bus_data_out   = b_q;
`ifdef ACCEL_READBACK_EN
                state_nxt      = S_RB_A;
`else
                state_nxt      = S_WR_OP;
`endif
            end
            S_RB_A: begin
                bus_address = 4'h0;
                state_nxt   = S_RB_B;
            end
            S_RB_B: begin
                bus_address = 4'h1;
                state_nxt   = S_WR_OP;
            end
            S_WR_OP: begin
                bus_address    = 4'h4;
                bus_data_write = 1'b1;
                bus_data_out   = {5'b0, op_q};
                state_nxt      = SKIP_WAIT ? S_RD_LO : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_RD_LO;
            end
            S_RD_LO: begin
                bus_address = 4'h5;
                state_nxt   = S_RD_HI;
            end
            S_RD_HI: begin
                bus_address = 4'h6;
                state_nxt   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job operands are pure data: latched on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= req_a;
            b_q  <= req_b;
            op_q <= req_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result <= 16'h0000;
            wait_cnt   <= 4'd0;
        end else begin
            if (state == S_WR_OP)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_RD_LO) rsp_result[7:0]  <= bus_data_in;
            if (state == S_RD_HI) rsp_result[15:8] <= bus_data_in;
        end
    end

`ifdef ACCEL_READBACK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= 1'b0;
        else if ((state == S_RB_A && bus_data_in != a_q) ||
                 (state == S_RB_B && bus_data_in != b_q))
            err_q <= 1'b1;
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
